// File: rtl/start_screen_pixel_gen_if.sv
// Scan-position inputs, animation pulses and palette-index outputs of the start-screen pixel generator.
interface start_screen_pixel_gen_if;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       pix_valid;
    logic       frame_tick;
    logic       start_enter;
    logic [3:0] start_color_index;
    logic       index_valid;

    modport master (
        output h_cnt, v_cnt, pix_valid, frame_tick, start_enter,
        input  start_color_index, index_valid
    );

    modport slave (
        input  h_cnt, v_cnt, pix_valid, frame_tick, start_enter,
        output start_color_index, index_valid
    );
endinterface

// File: rtl/start_screen_pixel_gen.sv
// Start-screen palette index generator: border, scrolling title stripes, prompt box; 2-stage pipeline.
// Optional macro START_BLINK_EN enables the blinking prompt (otherwise the prompt is a constant index 2).
module start_screen_pixel_gen #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int BORDER_W     = 4,
    parameter int TITLE_Y0     = 96,
    parameter int TITLE_H      = 64,
    parameter int PROMPT_X0    = 240,
    parameter int PROMPT_Y0    = 320,
    parameter int PROMPT_W     = 160,
    parameter int PROMPT_H     = 32,
    parameter int BLINK_FRAMES = 30
) (
    input logic                      clk,
    input logic                      rst_n,
    start_screen_pixel_gen_if.slave  pix
);

    localparam logic [9:0] BORDER_LO = 10'(BORDER_W);
    localparam logic [9:0] BORDER_HX = 10'(H_ACTIVE - BORDER_W);
    localparam logic [9:0] BORDER_HY = 10'(V_ACTIVE - BORDER_W);
    localparam logic [9:0] PROMPT_XA = 10'(PROMPT_X0);
    localparam logic [9:0] PROMPT_XB = 10'(PROMPT_X0 + PROMPT_W);
    localparam logic [9:0] PROMPT_YA = 10'(PROMPT_Y0);
    localparam logic [9:0] PROMPT_YB = 10'(PROMPT_Y0 + PROMPT_H);
    localparam logic [9:0] TITLE_YA  = 10'(TITLE_Y0);
    localparam logic [9:0] TITLE_YB  = 10'(TITLE_Y0 + TITLE_H);

    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("BLINK_FRAMES must be at least 1");
    end

    logic [5:0] scroll;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               scroll <= 6'd0;
        else if (pix.start_enter) scroll <= 6'd0;
        else if (pix.frame_tick)  scroll <= scroll + 6'd1;
    end

`ifdef START_BLINK_EN
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;
    logic               s1_blink;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (pix.start_enter) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (pix.frame_tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`endif

    logic       border_c, prompt_c, title_c;
    logic [5:0] stripe_sum;

    always_comb begin
        border_c = (pix.h_cnt < BORDER_LO) || (pix.h_cnt >= BORDER_HX) ||
                   (pix.v_cnt < BORDER_LO) || (pix.v_cnt >= BORDER_HY);
        prompt_c = (pix.h_cnt >= PROMPT_XA) && (pix.h_cnt < PROMPT_XB) &&
                   (pix.v_cnt >= PROMPT_YA) && (pix.v_cnt < PROMPT_YB);
        title_c  = (pix.v_cnt >= TITLE_YA) && (pix.v_cnt < TITLE_YB);
        // Only bits [5:4] of h+scroll are needed; the low six bits suffice.
        stripe_sum = pix.h_cnt[5:0] + scroll;
    end

    logic       s1_border, s1_prompt, s1_title, s1_valid;
    logic [1:0] s1_sel;

    // Blink state is captured alongside the pixel so it matches the sample cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_border <= 1'b0;
            s1_prompt <= 1'b0;
            s1_title  <= 1'b0;
            s1_sel    <= 2'd0;
            s1_valid  <= 1'b0;
`ifdef START_BLINK_EN
            s1_blink  <= 1'b1;
`endif
        end else begin
            s1_border <= border_c;
            s1_prompt <= prompt_c;
            s1_title  <= title_c;
            s1_sel    <= stripe_sum[5:4];
            s1_valid  <= pix.pix_valid;
`ifdef START_BLINK_EN
            s1_blink  <= blink_on;
`endif
        end
    end

    logic [3:0] prompt_idx, stripe_idx, index_c;

    always_comb begin
`ifdef START_BLINK_EN
        prompt_idx = s1_blink ? 4'd2 : 4'd6;
`else
        prompt_idx = 4'd2;
`endif
        case (s1_sel)
            2'd0:    stripe_idx = 4'd1;
            2'd1:    stripe_idx = 4'd3;
            2'd2:    stripe_idx = 4'd4;
            default: stripe_idx = 4'd5;
        endcase
        index_c = 4'd0;
        if (!s1_valid)      index_c = 4'd0;
        else if (s1_border) index_c = 4'd7;
        else if (s1_prompt) index_c = prompt_idx;
        else if (s1_title)  index_c = stripe_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix.start_color_index <= 4'd0;
            pix.index_valid       <= 1'b0;
        end else begin
            pix.start_color_index <= index_c;
            pix.index_valid       <= s1_valid;
        end
    end

endmodule

// File: tb/tb_start_screen_pixel_gen.sv
// Self-checking bench for start_screen_pixel_gen: directed test-plan points plus randomized pixels
// against a frame-count based reference model.
module tb_start_screen_pixel_gen;

    localparam int BF = 30;

    logic clk;
    logic rst_n;
    start_screen_pixel_gen_if pix();

    start_screen_pixel_gen #(.BLINK_FRAMES(BF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pix   (pix)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         ticks    = 0;
    logic [3:0] exp_idx [2];
    bit         exp_vld [2];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference: picture depends only on the pixel and frames elapsed since the last restart.
    function automatic logic [3:0] ref_idx(int h, int v, bit pv, int t);
        int  sel;
        bit  blink_on;
        if (!pv) return 4'd0;
        if (h < 4 || h >= 636 || v < 4 || v >= 476) return 4'd7;
`ifdef START_BLINK_EN
        blink_on = ((t / BF) % 2) == 0;
`else
        blink_on = 1'b1;
`endif
        if (h >= 240 && h < 400 && v >= 320 && v < 352) return blink_on ? 4'd2 : 4'd6;
        if (v >= 96 && v < 160) begin
            sel = ((h + (t % 64)) / 16) % 4;
            case (sel)
                0: return 4'd1;
                1: return 4'd3;
                2: return 4'd4;
                default: return 4'd5;
            endcase
        end
        return 4'd0;
    endfunction

    task automatic step(int h, int v, bit pv, bit ft, bit se);
        @(negedge clk);
        chk("index", {28'd0, pix.start_color_index}, {28'd0, exp_idx[1]});
        chk("valid", {31'd0, pix.index_valid}, {31'd0, exp_vld[1]});
        if (!rst_n) begin
            pv = 0; ft = 0; se = 0;
        end
        pix.h_cnt       = 10'(h);
        pix.v_cnt       = 10'(v);
        pix.pix_valid   = pv;
        pix.frame_tick  = ft;
        pix.start_enter = se;
        exp_idx[1] = exp_idx[0];
        exp_vld[1] = exp_vld[0];
        exp_idx[0] = rst_n ? ref_idx(h, v, pv, ticks) : 4'd0;
        exp_vld[0] = rst_n ? pv : 1'b0;
        if (rst_n) begin
            if (se)      ticks = 0;
            else if (ft) ticks++;
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic ticks_n(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0);
    endtask

    task automatic clear_model();
        exp_idx[0] = 4'd0; exp_idx[1] = 4'd0;
        exp_vld[0] = 1'b0; exp_vld[1] = 1'b0;
        ticks = 0;
    endtask

    int rh, rv, sel;

    initial begin
        rst_n = 1'b0;
        pix.h_cnt = '0; pix.v_cnt = '0;
        pix.pix_valid = 1'b0; pix.frame_tick = 1'b0; pix.start_enter = 1'b0;
        clear_model();
        idle(3);
        rst_n = 1'b1;

        step(0, 0, 1, 0, 0);
        step(320, 240, 1, 0, 0);
        step(100, 100, 1, 0, 0);
        step(95, 100, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(95, 100, 1, 0, 0);
        idle(2);

        step(300, 330, 1, 0, 0);
        ticks_n(29);
        step(300, 330, 1, 0, 0);
        step(300, 330, 1, 1, 0);
        step(300, 330, 1, 0, 0);
        ticks_n(29);
        step(300, 330, 1, 0, 0);
        step(300, 330, 1, 1, 0);
        step(300, 330, 1, 0, 0);
        ticks_n(4);
        step(95, 100, 1, 0, 0);
        idle(2);

        ticks_n(40);
        step(300, 330, 1, 1, 1);
        step(300, 330, 1, 0, 0);
        step(95, 100, 1, 0, 0);
        step(95, 100, 0, 0, 0);
        idle(2);

        step(0, 0, 1, 0, 0);
        step(2, 2, 1, 0, 0);
        step(639, 479, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_index", {28'd0, pix.start_color_index}, 32'd0);
        chk("async_rst_valid", {31'd0, pix.index_valid}, 32'd0);
        clear_model();
        idle(3);
        rst_n = 1'b1;
        idle(3);
        step(0, 0, 1, 0, 0);
        idle(2);

        for (int i = 0; i < 4000; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: begin rh = $urandom_range(230, 410); rv = $urandom_range(310, 360); end
                1: begin rh = $urandom_range(0, 639);   rv = $urandom_range(90, 165);  end
                2: begin
                    rh = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 8)   : $urandom_range(630, 639);
                    rv = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 479) : $urandom_range(0, 6);
                end
                default: begin rh = $urandom_range(0, 639); rv = $urandom_range(0, 479); end
            endcase
            step(rh, rv, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 299) == 0);
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/start_screen_pixel_gen.md
Name: start_screen_pixel_gen

Overview:
- Produces the per-pixel 4-bit start-screen palette index (0..7) from the VGA scan position. Feeds the start-state colour decoder directly.
- Draws a procedural start screen: a border, a colour-scrolling title band and a blinking prompt box.
- Two-stage registered pipeline. Animation counters advance once per frame.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- BORDER_W, 4, border thickness in pixels
- TITLE_Y0, 96, first title-band line
- TITLE_H, 64, title-band height in lines
- PROMPT_X0, 240, prompt box left column
- PROMPT_Y0, 320, prompt box top line
- PROMPT_W, 160, prompt box width
- PROMPT_H, 32, prompt box height
- BLINK_FRAMES, 30, frames per blink half-period (>=1)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- h_cnt  in  10  current pixel column
- v_cnt  in  10  current pixel line
- pix_valid  in  1  h_cnt/v_cnt inside the active area
- frame_tick  in  1  one-cycle pulse, once per frame, during blanking
- start_enter  in  1  one-cycle pulse when the top FSM enters the start state
- start_color_index  out  4  palette index to the colour decoder
- index_valid  out  1  start_color_index corresponds to a visible pixel

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - rst_n low clears all pipeline registers: start_color_index=0, index_valid=0.
  - Also clears scroll=0, blink_cnt=0, blink_on=1.
  - Takes effect immediately, mid-line or mid-frame. The first valid output appears 2 cycles after the first pix_valid following release.
- Latency: exactly 2 clk.
  - Stage 1 registers the region flags (border, prompt, title), the stripe select and pix_valid.
  - Stage 2 registers the priority-muxed index and index_valid.
  - Throughput: 1 pixel per clk, no stalls.
- Region rules (unsigned compares, half-open ranges):
  - border: h<BORDER_W, or h>=H_ACTIVE-BORDER_W, or v<BORDER_W, or v>=V_ACTIVE-BORDER_W.
  - prompt: PROMPT_X0<=h<PROMPT_X0+PROMPT_W and PROMPT_Y0<=v<PROMPT_Y0+PROMPT_H.
  - title: TITLE_Y0<=v<TITLE_Y0+TITLE_H.
- Index priority: border -> 7; else prompt -> (blink_on ? 2 : 6); else title -> stripe colour; else 0.
- Stripe colour:
  - sel = ((h_cnt + scroll) >> 4) mod 4, with the sum computed in 11 bits (no overflow).
  - sel 0,1,2,3 map to index 1,3,4,5.
- pix_valid low: the stage-2 index is forced to 0 and index_valid=0. Indices 8..15 are never produced.
- Animation counters (priority: rst_n > start_enter > frame_tick):
  - start_enter: scroll=0, blink_cnt=0, blink_on=1, on the next edge.
  - frame_tick: scroll increments mod 64 (63 wraps to 0).
  - frame_tick: blink_cnt increments; when it reaches BLINK_FRAMES-1 it wraps to 0 and blink_on toggles.
  - start_enter and frame_tick in the same cycle: start_enter wins and the tick is dropped.
- Counter updates are visible to pixels sampled in stage 1 on the cycle after the updating edge. A pixel sampled in the same cycle as frame_tick uses the old values.

Optional Feature:
- Macro START_BLINK_EN.
- Defined: prompt blinks as above.
- Undefined: blink_cnt/blink_on logic is not generated, the prompt is constant index 2, and BLINK_FRAMES is ignored. Scroll behaviour is unchanged.

Test Plan:
- Reset, then pixel (0,0) valid -> 2 clk later: index 7, index_valid 1. Pixel (320,240) valid -> index 0.
- scroll=0, pixel (100,100) -> index 4. Pixel (95,100) -> index 3. After one frame_tick (scroll=1): pixel (95,100) -> index 4.
- Pixel (300,330), START_BLINK_EN defined:
  - index 2 after reset.
  - index 6 after 30 frame_ticks.
  - index 2 after 60 frame_ticks.
  - With the macro undefined: index 2 throughout.
- 64 frame_ticks -> scroll wraps to 0: pixel (95,100) -> index 3 again.
- Assert start_enter together with frame_tick after 40 ticks -> scroll=0 and blink_on=1, so pixel (300,330) -> index 2 and (95,100) -> index 3. Deassert pix_valid -> index 0, index_valid 0 after 2 clk.
- Drop rst_n mid-line with the pipeline full -> outputs go to 0/0 within the same cycle, without waiting for a clk edge. After release, the output holds 0 until 2 clk after the next pix_valid.
